// File: rtl/packet_arbiter_pkg.sv
// Shared definitions for the packet arbiter and related stream muxes: FSM
// state encoding and a one-hot to binary index helper.
package packet_arbiter_pkg;

    localparam int MAX_SOURCES = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Lowest set bit wins if more than one bit is set.
    function automatic logic [3:0] onehot_to_index(input logic [MAX_SOURCES-1:0] onehot);
        logic [3:0] index;
        index = '0;
        for (int i = MAX_SOURCES - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                index = 4'(i);
            end
        end
        return index;
    endfunction

endpackage

// File: rtl/packet_arbiter_if.sv
// Stream bundle between N sources, the arbiter and one packet FIFO write port.
// master: arbiter view; slave: sources/FIFO view.
interface packet_arbiter_if #(
    parameter int NUM   = 4,
    parameter int WIDTH = 8
);
    logic [NUM-1:0]       s_valid_i;
    logic [NUM-1:0]       s_ready_o;
    logic [NUM-1:0]       s_last_i;
    logic [NUM-1:0]       s_drop_i;
    logic [NUM*WIDTH-1:0] s_data_i;
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic                 m_last_o;
    logic                 m_drop_o;
    logic [WIDTH-1:0]     m_data_o;

    modport master (
        input  s_valid_i, s_last_i, s_drop_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_last_o, m_drop_o, m_data_o
    );

    modport slave (
        output s_valid_i, s_last_i, s_drop_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_last_o, m_drop_o, m_data_o
    );
endinterface

// File: rtl/packet_arbiter_rr_arbiter_pick.sv
// Combinational round-robin pick: first requester at or after the pointer,
// searching cyclically. Returns one-hot grant and its binary index.
module rr_arbiter_pick
    import packet_arbiter_pkg::*;
#(
    parameter int NUM = 4,
    parameter int IW  = $clog2(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NUM-1:0] grant,
    output logic [IW-1:0]  index
);

    int            cand;
    logic [IW-1:0] cand_idx;
    logic          found;

    always_comb begin
        grant    = '0;
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            cand     = (int'(ptr) + i) % NUM;
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
            end
        end
    end

    assign index = IW'(onehot_to_index(MAX_SOURCES'(grant)));

endmodule

// File: rtl/packet_arbiter.sv
// Packet-granular round-robin arbiter feeding one packet FIFO write port.
// Optional mid-packet stall timeout: define PACKET_ARBITER_TIMEOUT_EN.
module packet_arbiter
    import packet_arbiter_pkg::*;
#(
    parameter int NUM     = 4,
    parameter int WIDTH   = 8,
    parameter int CBITS   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    packet_arbiter_if.master  bus,
    output logic [NUM-1:0]    grant_o,
    output logic              busy_o,
    output logic [CBITS-1:0]  pkt_count_o
);

    localparam int IW = $clog2(NUM);

    state_t           state_reg, state_next;
    logic [NUM-1:0]   grant_reg, grant_next;
    logic [IW-1:0]    gidx_reg, gidx_next;
    logic [IW-1:0]    ptr_reg, ptr_next, ptr_after;
    logic [CBITS-1:0] count_reg, count_next;

    logic [NUM-1:0]   pick_grant;
    logic [IW-1:0]    pick_idx;
    logic [WIDTH-1:0] data_arr [NUM];

    logic busy, g_valid, g_last, g_drop, xfer, timeout_hit, release_drop, done_last;

    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
            assign data_arr[gi] = bus.s_data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter_pick #(.NUM(NUM), .IW(IW)) u_pick (
        .req   (bus.s_valid_i),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .index (pick_idx)
    );

    assign busy         = (state_reg == ST_BUSY);
    assign g_valid      = busy & bus.s_valid_i[gidx_reg];
    assign g_last       = busy & bus.s_last_i[gidx_reg];
    assign g_drop       = busy & bus.s_drop_i[gidx_reg];
    assign xfer         = g_valid & bus.m_ready_i;
    assign release_drop = g_drop | timeout_hit;
    // A drop on the same cycle as the last beat aborts the packet instead.
    assign done_last    = xfer & g_last & ~release_drop;
    assign ptr_after    = (gidx_reg == IW'(NUM - 1)) ? '0 : gidx_reg + 1'b1;

`ifdef PACKET_ARBITER_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_reg, stall_next;

    assign timeout_hit = busy & ~g_valid & (stall_reg == SW'(TIMEOUT - 1));

    always_comb begin
        stall_next = '0;
        if (busy && !g_valid && !timeout_hit) begin
            stall_next = stall_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_reg <= '0;
        end else begin
            stall_reg <= stall_next;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        gidx_next  = gidx_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|bus.s_valid_i) begin
                    state_next = ST_BUSY;
                    grant_next = pick_grant;
                    gidx_next  = pick_idx;
                end
            end
            ST_BUSY: begin
                if (release_drop || done_last) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    ptr_next   = ptr_after;
                    if (done_last) begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            gidx_reg  <= '0;
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            gidx_reg  <= gidx_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
        end
    end

    assign bus.m_valid_o = g_valid;
    assign bus.m_last_o  = g_last & ~release_drop;
    assign bus.m_drop_o  = release_drop;
    assign bus.m_data_o  = busy ? data_arr[gidx_reg] : '0;
    assign bus.s_ready_o = busy ? (grant_reg & {NUM{bus.m_ready_i}}) : '0;

    assign grant_o     = grant_reg;
    assign busy_o      = busy;
    assign pkt_count_o = count_reg;

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed bench for packet_arbiter: cycle vector table plus hand-written
// sequences for ready toggling, reset mid-packet, fairness, wrap and stall.
module tb_packet_arbiter;

    localparam int NUM   = 4;
    localparam int WIDTH = 8;
    localparam int CBITS = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [NUM-1:0]   grant;
    logic             busy;
    logic [CBITS-1:0] pkt_count;

    int n_cmp  = 0;
    int n_fail = 0;

    packet_arbiter_if #(.NUM(NUM), .WIDTH(WIDTH)) bus ();

    packet_arbiter #(.NUM(NUM), .WIDTH(WIDTH), .CBITS(CBITS), .TIMEOUT(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .grant_o     (grant),
        .busy_o      (busy),
        .pkt_count_o (pkt_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [3:0]  d;
        logic [31:0] data;
        logic [3:0]  e_grant;
        logic        e_mv;
        logic        e_ml;
        logic        e_md;
        logic [7:0]  e_mdata;
        logic [3:0]  e_sr;
        logic        e_busy;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dv;
        logic [3:0]  lv;
        int          b;
        int          beats [NUM];

        //         v       l       d       data          grant   mv ml md mdata  sr      busy cnt
        tbl[0]  = '{4'b0100,4'b0000,4'b0000,32'h00A1_0000, 4'b0000,0, 0, 0, 8'h00, 4'b0000,0,   4'd0};
        tbl[1]  = '{4'b0100,4'b0000,4'b0000,32'h00A1_0000, 4'b0100,1, 0, 0, 8'hA1, 4'b0100,1,   4'd0};
        tbl[2]  = '{4'b0100,4'b0000,4'b0000,32'h00A2_0000, 4'b0100,1, 0, 0, 8'hA2, 4'b0100,1,   4'd0};
        tbl[3]  = '{4'b0100,4'b0100,4'b0000,32'h00A3_0000, 4'b0100,1, 1, 0, 8'hA3, 4'b0100,1,   4'd0};
        tbl[4]  = '{4'b0000,4'b0000,4'b0000,32'h0000_0000, 4'b0000,0, 0, 0, 8'h00, 4'b0000,0,   4'd1};
        tbl[5]  = '{4'b0010,4'b0000,4'b0000,32'h0000_B100, 4'b0000,0, 0, 0, 8'h00, 4'b0000,0,   4'd1};
        tbl[6]  = '{4'b0010,4'b0000,4'b0000,32'h0000_B100, 4'b0010,1, 0, 0, 8'hB1, 4'b0010,1,   4'd1};
        tbl[7]  = '{4'b0010,4'b0000,4'b0000,32'h0000_B200, 4'b0010,1, 0, 0, 8'hB2, 4'b0010,1,   4'd1};
        tbl[8]  = '{4'b1110,4'b0000,4'b1010,32'hD1C1_B300, 4'b0010,1, 0, 1, 8'hB3, 4'b0010,1,   4'd1};
        tbl[9]  = '{4'b1100,4'b0000,4'b1000,32'hD1C1_0000, 4'b0000,0, 0, 0, 8'h00, 4'b0000,0,   4'd1};
        tbl[10] = '{4'b1100,4'b0100,4'b1000,32'hD1C1_0000, 4'b0100,1, 1, 0, 8'hC1, 4'b0100,1,   4'd1};
        tbl[11] = '{4'b1000,4'b1000,4'b0000,32'hD100_0000, 4'b0000,0, 0, 0, 8'h00, 4'b0000,0,   4'd2};
        tbl[12] = '{4'b1000,4'b1000,4'b0000,32'hD100_0000, 4'b1000,1, 1, 0, 8'hD1, 4'b1000,1,   4'd2};
        tbl[13] = '{4'b0001,4'b0000,4'b0000,32'h0000_00E1, 4'b0000,0, 0, 0, 8'h00, 4'b0000,0,   4'd3};
        tbl[14] = '{4'b0001,4'b0001,4'b0001,32'h0000_00E1, 4'b0001,1, 0, 1, 8'hE1, 4'b0001,1,   4'd3};
        tbl[15] = '{4'b0000,4'b0000,4'b0000,32'h0000_0000, 4'b0000,0, 0, 0, 8'h00, 4'b0000,0,   4'd3};

        reset         = 1'b1;
        bus.s_valid_i = '0;
        bus.s_last_i  = '0;
        bus.s_drop_i  = '0;
        bus.s_data_i  = '0;
        bus.m_ready_i = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_count", 32'(pkt_count), 32'h0);
        tick();
        reset = 1'b0;

        // Vector table: single packet, drop with ungranted drop, drop+last.
        for (int i = 0; i < 16; i++) begin
            bus.s_valid_i = tbl[i].v;
            bus.s_last_i  = tbl[i].l;
            bus.s_drop_i  = tbl[i].d;
            bus.s_data_i  = tbl[i].data;
            bus.m_ready_i = 1'b1;
            @(negedge clock);
            $display("vec %0d: grant=%b mv=%b ml=%b md=%b data=%h cnt=%0d",
                     i, grant, bus.m_valid_o, bus.m_last_o, bus.m_drop_o, bus.m_data_o, pkt_count);
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
            chk($sformatf("vec%0d_mvalid", i), 32'(bus.m_valid_o), 32'(tbl[i].e_mv));
            chk($sformatf("vec%0d_mlast", i), 32'(bus.m_last_o), 32'(tbl[i].e_ml));
            chk($sformatf("vec%0d_mdrop", i), 32'(bus.m_drop_o), 32'(tbl[i].e_md));
            chk($sformatf("vec%0d_mdata", i), 32'(bus.m_data_o), 32'(tbl[i].e_mdata));
            chk($sformatf("vec%0d_sready", i), 32'(bus.s_ready_o), 32'(tbl[i].e_sr));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d_count", i), 32'(pkt_count), 32'(tbl[i].e_cnt));
            tick();
        end

        // Ready toggling on a 4-beat packet from source 1; source 2 waits.
        bus.s_valid_i = 4'b0110;
        bus.s_last_i  = '0;
        bus.s_drop_i  = '0;
        bus.s_data_i  = 32'h0055_D000;
        bus.m_ready_i = 1'b0;
        @(negedge clock);
        chk("toggle_idle_grant", 32'(grant), 32'h0);
        tick();
        b = 0;
        for (int i = 0; i < 7; i++) begin
            bus.m_ready_i = (i % 2 == 0);
            bus.s_data_i  = {8'h00, 8'h55, 8'(8'hD0 + b), 8'h00};
            bus.s_last_i  = {2'b00, (b == 3), 1'b0};
            @(negedge clock);
            chk("toggle_grant", 32'(grant), 32'h2);
            chk("toggle_sready", 32'(bus.s_ready_o), 32'({2'b00, bus.m_ready_i, 1'b0}));
            chk("toggle_mdata", 32'(bus.m_data_o), 32'(8'hD0 + b));
            chk("toggle_mlast", 32'(bus.m_last_o), 32'(b == 3));
            if (bus.m_ready_i) begin
                $display("toggle beat %0d data=%h", b, bus.m_data_o);
                b++;
            end
            tick();
        end
        bus.s_valid_i = 4'b0100;
        bus.s_last_i  = '0;
        @(negedge clock);
        chk("toggle_done_busy", 32'(busy), 32'h0);
        chk("toggle_done_count", 32'(pkt_count), 32'd4);
        tick();

        // Reset while source 2 is mid-packet.
        bus.m_ready_i = 1'b1;
        @(negedge clock);
        chk("rst_pre_grant", 32'(grant), 32'h4);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clock);
        $display("reset mid-packet: grant=%b busy=%b cnt=%0d", grant, busy, pkt_count);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", 32'(pkt_count), 32'h0);
        chk("rst_mdrop", 32'(bus.m_drop_o), 32'h0);
        tick();
        reset         = 1'b0;
        bus.s_valid_i = 4'b1010;
        tick();
        @(negedge clock);
        chk("rst_first_grant", 32'(grant), 32'h2);
        tick();

        // Fairness: every source sends 2-beat packets continuously.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < NUM; k++) beats[k] = 0;
        bus.s_valid_i = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            int p, ph, g;
            p  = c / 3;
            ph = c % 3;
            g  = p % NUM;
            for (int k = 0; k < NUM; k++) begin
                dv[k*8 +: 8] = 8'(k * 16 + beats[k]);
                lv[k]        = (beats[k] == 1);
            end
            bus.s_data_i = dv;
            bus.s_last_i = lv;
            @(negedge clock);
            if (ph == 0) begin
                chk("fair_bubble", 32'(grant), 32'h0);
            end else begin
                chk("fair_grant", 32'(grant), 32'(1 << g));
                chk("fair_mdata", 32'(bus.m_data_o), 32'(g * 16 + ph - 1));
                chk("fair_mlast", 32'(bus.m_last_o), 32'(ph == 2));
                if (ph == 2) $display("fair packet %0d from source %0d", p, g);
            end
            tick();
            if (ph != 0) beats[g] = (beats[g] + 1) % 2;
        end
        bus.s_valid_i = '0;
        @(negedge clock);
        chk("fair_count", 32'(pkt_count), 32'd5);
        tick();

        // Counter wrap with single-beat packets from source 0.
        bus.s_valid_i = 4'b0001;
        bus.s_last_i  = 4'b0001;
        for (int n = 0; n < 11; n++) begin
            @(negedge clock);
            chk("wrap_count", 32'(pkt_count), 32'((5 + n) % 16));
            tick();
            @(negedge clock);
            chk("wrap_mlast", 32'(bus.m_last_o), 32'h1);
            tick();
        end
        bus.s_valid_i = '0;
        bus.s_last_i  = '0;
        @(negedge clock);
        $display("wrap: count=%0d", pkt_count);
        chk("wrap_zero", 32'(pkt_count), 32'h0);
        tick();

        // Mid-packet stall by source 1 with source 2 waiting.
        bus.s_valid_i = 4'b0110;
        bus.s_data_i  = 32'h0000_7700;
        tick();
        @(negedge clock);
        chk("stall_grant", 32'(grant), 32'h2);
        tick();
        bus.s_valid_i = 4'b0100;
`ifdef PACKET_ARBITER_TIMEOUT_EN
        for (int s = 1; s <= 8; s++) begin
            @(negedge clock);
            chk("timeout_grant", 32'(grant), 32'h2);
            chk("timeout_mdrop", 32'(bus.m_drop_o), 32'(s == 8));
            tick();
        end
        @(negedge clock);
        chk("timeout_release", 32'(grant), 32'h0);
        chk("timeout_mdrop_after", 32'(bus.m_drop_o), 32'h0);
        tick();
        @(negedge clock);
        $display("timeout: next grant=%b", grant);
        chk("timeout_next", 32'(grant), 32'h4);
        chk("timeout_count", 32'(pkt_count), 32'h0);
`else
        for (int s = 1; s <= 20; s++) begin
            @(negedge clock);
            chk("stall_hold", 32'(grant), 32'h2);
            chk("stall_nodrop", 32'(bus.m_drop_o), 32'h0);
            tick();
        end
        bus.s_valid_i = 4'b0110;
        bus.s_last_i  = 4'b0010;
        @(negedge clock);
        chk("stall_resume_last", 32'(bus.m_last_o), 32'h1);
        tick();
        bus.s_valid_i = 4'b0100;
        bus.s_last_i  = '0;
        tick();
        @(negedge clock);
        $display("stall: next grant=%b cnt=%0d", grant, pkt_count);
        chk("stall_next", 32'(grant), 32'h4);
        chk("stall_count", 32'(pkt_count), 32'h1);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_arbiter.md
Name: packet_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one packet FIFO write port between N AXI-stream-style sources.
- Grant is held for a whole packet and released on the last beat or on a drop; a drop request is forwarded so the FIFO rewinds the partial packet.
- Sits directly in front of a packet FIFO's valid/ready/last/drop/data write port.

Parameters:
- NUM, 4, number of requesting sources (2..16).
- WIDTH, 8, data width per beat.
- CBITS, 16, width of the accepted-packet counter.
- TIMEOUT, 255, mid-packet stall limit in cycles; used only with the optional feature.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- s_valid_i  input  NUM  per-source beat valid
- s_ready_o  output  NUM  per-source beat ready
- s_last_i  input  NUM  per-source last beat of packet
- s_drop_i  input  NUM  per-source abort of current packet
- s_data_i  input  NUM*WIDTH  source data; source k occupies bits [k*WIDTH +: WIDTH]
- m_valid_o  output  1  to FIFO valid_i
- m_ready_i  input  1  from FIFO ready_o
- m_last_o  output  1  to FIFO last_i
- m_drop_o  output  1  to FIFO drop_i
- m_data_o  output  WIDTH  to FIFO data_i
- grant_o  output  NUM  one-hot current grant; zero when idle
- busy_o  output  1  a packet is in progress
- pkt_count_o  output  CBITS  packets completed with last (drops excluded), wraps modulo 2^CBITS

Behaviour:
- Reset: state IDLE, grant_o=0, busy_o=0, pkt_count_o=0, round-robin pointer=0 (source 0 has highest priority). All outputs are 0 while idle: m_valid_o, m_last_o, m_drop_o, m_data_o=0, s_ready_o=0.
- States:
  - IDLE: if any s_valid_i is set, register grant = first requester at or after the pointer, cyclically; go to BUSY. One cycle of arbitration latency, so there is a single idle bubble between packets.
  - BUSY, with granted index g:
    - m_valid_o=s_valid_i[g], m_last_o=s_last_i[g], m_data_o=source g data.
    - s_ready_o[g]=m_ready_i; s_ready_o for all other sources is 0.
    - These paths are combinational from the registered grant; there is no data register.
- Beat transfer: s_valid_i[g] && m_ready_i.
- End of packet on a transfer with s_last_i[g]=1:
  - pkt_count_o increments next cycle.
  - Pointer becomes g+1 mod NUM.
  - Return to IDLE.
- Drop: s_drop_i[g] high in BUSY gives m_drop_o=1 that same cycle, independent of valid.
  - The grant is released, the pointer advances to g+1, return to IDLE, and the count is unchanged.
  - If drop and a last transfer coincide, drop wins: m_last_o is forced to 0 that cycle and there is no count.
- s_drop_i from non-granted sources, and any drop while IDLE, are ignored; m_drop_o is never asserted outside BUSY.
- A source that deasserts valid mid-packet keeps the grant; there is no preemption.
- Fairness: with all NUM sources continuously requesting, grants cycle 0,1,..,NUM-1,0.
- Reset mid-packet: the grant is cleared immediately with no drop pulse. The FIFO shares the reset, so no partial packet survives.
- Wrap: pkt_count_o rolls from 2^CBITS-1 to 0.

Optional Feature:
- Macro PACKET_ARBITER_TIMEOUT_EN.
- Defined:
  - A stall counter runs in BUSY, counting consecutive cycles with s_valid_i[g]=0.
  - It resets on any granted valid and on entry to BUSY.
  - When it reaches TIMEOUT, m_drop_o pulses for 1 cycle, the grant is released as for a drop, and the pointer advances.
- Undefined: no counter exists; a stalled source holds the grant indefinitely. The TIMEOUT parameter is ignored.

Decomposition:
- Shared include/package: state encoding constants (ST_IDLE, ST_BUSY) and a one-hot-to-index function. These are reused by other stream muxes.
- One natural sub-module, rr_arbiter_pick: purely combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - Instantiated once in the IDLE path.

Test Plan:
- NUM=4, WIDTH=8, a single source 2 sends a 3-beat packet 0xA1,0xA2,0xA3 (last on the third beat) with m_ready_i=1 → grant_o=4'b0100 one cycle after valid, 3 beats out in order with m_last_o on 0xA3, pkt_count_o=1, busy_o=0 afterwards.
- All 4 sources request 2-beat packets continuously → grant order 0,1,2,3,0, each with one idle cycle between packets, and no interleaving of beats.
- Source 1 mid-packet (after 2 beats) raises s_drop_i, while source 3 raises drop ungranted → one m_drop_o pulse attributed to source 1, pkt_count_o unchanged, next grant goes to 2 or 3 per the pointer, and source 3's drop has no effect.
- m_ready_i toggles 1,0,1,0 during a 4-beat packet → s_ready_o[g] mirrors m_ready_i, no beat is lost or duplicated, and ungranted s_ready_o stays 0.
- Reset asserted in BUSY after 1 beat → next cycle grant_o=0, busy_o=0, pkt_count_o=0, m_drop_o=0; the first grant after reset goes to the lowest requesting index.
- With PACKET_ARBITER_TIMEOUT_EN and TIMEOUT=8, the granted source stalls for 8 cycles → m_drop_o pulses exactly once on the 8th stall cycle and the grant passes to the next requester.
